// File: rtl/led_sequencer.sv
// LED pattern sequencer: a run-gated prescaler emits one tick per DIV clocks, and each tick
// steps one of four LED patterns (binary count, rotate, bounce, breathe).
module led_sequencer #(
  parameter int unsigned NLEDS    = 5,
  parameter int unsigned DIV      = 900000,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic             clki,
  input  logic             resetn,
  input  logic             run,
  input  logic [1:0]       mode,
  output logic [NLEDS-1:0] led,
  output logic             tick
);

  localparam int unsigned PW   = $clog2(DIV);
  localparam int unsigned POSW = (NLEDS > 1) ? $clog2(NLEDS) : 1;

  localparam logic [PW-1:0]       PRE_LAST = PW'(DIV - 1);
  localparam logic [POSW-1:0]     POS_LAST = POSW'(NLEDS - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;

  typedef enum logic [1:0] {
    MODE_BIN = 2'd0,
    MODE_ROT = 2'd1,
    MODE_BNC = 2'd2,
    MODE_BRE = 2'd3
  } mode_e;

  logic [PW-1:0]       presc_q, presc_d;
  logic                tick_q,  tick_d;
  mode_e               mode_q,  mode_d;
  logic [NLEDS-1:0]    cnt_q,   cnt_d;
  logic [NLEDS-1:0]    rot_q,   rot_d;
  logic [POSW-1:0]     pos_q,   pos_d;
  logic                bdown_q, bdown_d;
  logic [PWM_BITS-1:0] lvl_q,   lvl_d;
  logic                ldown_q, ldown_d;
  logic [PWM_BITS-1:0] pwm_q,   pwm_d;
  logic [NLEDS-1:0]    led_q,   led_d;
  logic                step;

  // Next-state: prescaler, pattern step on wrap, then LED decode of the next state
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    rot_d   = rot_q;
    pos_d   = pos_q;
    bdown_d = bdown_q;
    lvl_d   = lvl_q;
    ldown_d = ldown_q;
    pwm_d   = pwm_q + PWM_BITS'(1);
    led_d   = '0;
    step    = 1'b0;

    if (run) begin
      if (presc_q == PRE_LAST) begin
        presc_d = '0;
        step    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    tick_d = step;

    if (step) begin
      if (mode_e'(mode) != mode_q) begin
        // Entering a mode always restarts every pattern from its initial state
        mode_d  = mode_e'(mode);
        cnt_d   = '0;
        rot_d   = NLEDS'(1);
        pos_d   = '0;
        bdown_d = 1'b0;
        lvl_d   = '0;
        ldown_d = 1'b0;
      end else begin
        unique case (mode_q)
          MODE_BIN: cnt_d = cnt_q + NLEDS'(1);
          MODE_ROT: rot_d = (rot_q << 1) | (rot_q >> (NLEDS - 1));
          MODE_BNC: begin
            // With a single LED both endpoints coincide, so pos never moves
            if (!bdown_q && pos_q != POS_LAST) begin
              pos_d = pos_q + POSW'(1);
              if (pos_d == POS_LAST) bdown_d = 1'b1;
            end else if (bdown_q && pos_q != '0) begin
              pos_d = pos_q - POSW'(1);
              if (pos_d == '0) bdown_d = 1'b0;
            end
          end
          MODE_BRE: begin
            if (!ldown_q) begin
              lvl_d = lvl_q + PWM_BITS'(1);
              if (lvl_d == LVL_MAX) ldown_d = 1'b1;
            end else begin
              lvl_d = lvl_q - PWM_BITS'(1);
              if (lvl_d == '0) ldown_d = 1'b0;
            end
          end
        endcase
      end
    end

    unique case (mode_d)
      MODE_BIN: led_d = cnt_d;
      MODE_ROT: led_d = rot_d;
      MODE_BNC: led_d = NLEDS'(1) << pos_d;
      MODE_BRE: led_d = {NLEDS{pwm_d < lvl_d}};
    endcase
  end

  always_ff @(posedge clki or negedge resetn) begin
    if (!resetn) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      mode_q  <= MODE_BIN;
      cnt_q   <= '0;
      rot_q   <= NLEDS'(1);
      pos_q   <= '0;
      bdown_q <= 1'b0;
      lvl_q   <= '0;
      ldown_q <= 1'b0;
      pwm_q   <= '0;
      led_q   <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      rot_q   <= rot_d;
      pos_q   <= pos_d;
      bdown_q <= bdown_d;
      lvl_q   <= lvl_d;
      ldown_q <= ldown_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: per-cycle comparison against a step-count pattern
// model, plus directed pattern sequences, run freeze, mode timing and async reset.
module tb_led_sequencer;

  localparam int unsigned N = 5;
  localparam int unsigned D = 4;
  localparam int unsigned P = 2;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         run = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [N-1:0] led;
  logic         tick;

  int checks = 0;
  int errors = 0;

  int bpos [10] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
  int blvl [7]  = '{0, 1, 2, 3, 2, 1, 0};

  led_sequencer #(.NLEDS(N), .DIV(D), .PWM_BITS(P)) dut (
    .clki  (clk),
    .resetn(resetn),
    .run   (run),
    .mode  (mode),
    .led   (led),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  // Pattern value after st steps since the mode was entered
  function automatic logic [N-1:0] exp_led(input int md, input int st, input int pw);
    int p;
    int per;
    int lmax;
    case (md)
      0: return N'(st % (1 << N));
      1: return N'(1) << (st % N);
      2: begin
        per = 2 * (N - 1);
        if (per == 0) p = 0;
        else begin
          p = st % per;
          if (p >= N) p = per - p;
        end
        return N'(1) << p;
      end
      default: begin
        lmax = (1 << P) - 1;
        per  = 2 * lmax;
        p    = st % per;
        if (p > lmax) p = per - p;
        return (pw < p) ? {N{1'b1}} : {N{1'b0}};
      end
    endcase
  endfunction

  int       m_presc = 0;
  int       m_pwm   = 0;
  int       m_mode  = 0;
  int       m_steps = 0;
  logic     m_tick  = 1'b0;
  logic     s_run;
  logic     s_rstn;
  logic [1:0] s_mode;
  logic [N-1:0] m_led;

  // Reference model and per-cycle compare: inputs sampled at the rising edge, checked at the falling edge
  always begin
    @(posedge clk);
    s_run  = run;
    s_mode = mode;
    s_rstn = resetn;
    @(negedge clk);
    if (!resetn || !s_rstn) begin
      m_presc = 0;
      m_pwm   = 0;
      m_mode  = 0;
      m_steps = 0;
      m_tick  = 1'b0;
    end else begin
      m_pwm  = (m_pwm + 1) % (1 << P);
      m_tick = 1'b0;
      if (s_run) begin
        if (m_presc == D - 1) begin
          m_presc = 0;
          m_tick  = 1'b1;
        end else begin
          m_presc = m_presc + 1;
        end
      end
      if (m_tick) begin
        if (int'(s_mode) != m_mode) begin
          m_mode  = int'(s_mode);
          m_steps = 0;
        end else begin
          m_steps = m_steps + 1;
        end
      end
    end
    m_led = exp_led(m_mode, m_steps, m_pwm);
    checks = checks + 2;
    if (tick !== m_tick) begin
      errors = errors + 1;
      $display("FAIL model_tick t=%0t actual %b required %b", $time, tick, m_tick);
    end
    if (led !== m_led) begin
      errors = errors + 1;
      $display("FAIL model_led t=%0t actual %b required %b", $time, led, m_led);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for the next tick (returns 1ns after that edge); n = edges waited
  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      n = n + 1;
      if (tick === 1'b1) return;
    end
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL tick_timeout actual %0d cycles required a tick", n);
  endtask

  initial begin
    int n;
    int hi;
    int bad;
    int tcount;
    int r;

    cycles(3);
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);

    resetn = 1'b1;
    run    = 1'b1;
    wait_tick(n);
    chk("first_tick_latency", 32'(n), 32'(D));
    chk("bin_after_1", 32'(led), 32'b00001);
    wait_tick(n);
    chk("tick_period", 32'(n), 32'(D));
    wait_tick(n);
    chk("bin_after_3", 32'(led), 32'b00011);
    repeat (29) wait_tick(n);
    chk("bin_wrap_32", 32'(led), 32'b00000);

    cycles(1);
    run    = 1'b0;
    tcount = 0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (tick === 1'b1) tcount = tcount + 1;
    end
    chk("freeze_no_tick", 32'(tcount), 32'h0);
    chk("freeze_led_hold", 32'(led), 32'b00000);
    run = 1'b1;
    wait_tick(n);
    chk("freeze_resume_phase", 32'(n), 32'(D - 1));
    chk("bin_after_freeze", 32'(led), 32'b00001);

    cycles(1);
    mode = 2'd1;
    cycles(2);
    chk("rot_pending_hold", 32'(led), 32'b00001);
    wait_tick(n);
    chk("rot_load", 32'(led), 32'b00001);
    for (int k = 1; k <= 5; k++) begin
      wait_tick(n);
      chk("rot_step", 32'(led), 32'(1 << (k % 5)));
    end
    wait_tick(n);

    cycles(1);
    mode = 2'd2;
    cycles(2);
    chk("bnc_pending_hold", 32'(led), 32'b00010);
    for (int k = 0; k < 10; k++) begin
      wait_tick(n);
      chk("bnc_pos", 32'(led), 32'(1 << bpos[k]));
    end

    mode = 2'd3;
    bad  = 0;
    for (int k = 0; k < 7; k++) begin
      wait_tick(n);
      hi = 0;
      for (int j = 0; j < 4; j++) begin
        if (j > 0) cycles(1);
        if (led === {N{1'b1}}) hi = hi + 1;
        else if (led !== {N{1'b0}}) bad = bad + 1;
      end
      chk("bre_level", 32'(hi), 32'(blvl[k]));
    end
    chk("bre_uniform", 32'(bad), 32'h0);

    mode = 2'd1;
    wait_tick(n);
    chk("rot_reenter", 32'(led), 32'b00001);
    wait_tick(n);
    wait_tick(n);
    chk("rot_before_reset", 32'(led), 32'b00100);
    #1 resetn = 1'b0;
    #1;
    chk("async_reset_led", 32'(led), 32'h0);
    chk("async_reset_tick", 32'(tick), 32'h0);
    cycles(2);
    resetn = 1'b1;
    wait_tick(n);
    chk("post_reset_latency", 32'(n), 32'(D));
    chk("post_reset_rot_load", 32'(led), 32'b00001);

    for (int i = 0; i < 3000; i++) begin
      cycles(1);
      r = $urandom_range(0, 99);
      if (r < 8) run = ($urandom_range(0, 4) != 0);
      else if (r < 12) mode = 2'($urandom_range(0, 3));
      else if (r == 12) begin
        #1 resetn = 1'b0;
        cycles($urandom_range(1, 3));
        resetn = 1'b1;
      end
    end

    cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

endmodule
